// File: rtl/lcd_value_writer.sv
// Signed sample -> blank-padded decimal field in the 1602 LCD buffer, then one repaint request.
// Latency: accept edge 0, W conversion cycles, DIGITS+1 buffer writes, repaint from cycle W+DIGITS+2.
// Backpressure: value_ready low from accept until the repaint pulse; repaint waits while lcd_busy is high.
module lcd_value_writer #(
    parameter int W         = 24,
    parameter int DIGITS    = 8,
    parameter int LINE_BASE = 0,
    parameter int COL       = 4
) (
    input  logic         CLK12,
    input  logic         reset_n,
    input  logic [W-1:0] value,
    input  logic         value_valid,
    output logic         value_ready,
    input  logic         lcd_busy,
    output logic [7:0]   lcd_dat,
    output logic [6:0]   lcd_addr,
    output logic         lcd_we,
    output logic         lcd_repaint
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(W + DIGITS + 1);
    localparam logic [CW-1:0] CONV_LAST  = CW'(W - 1);
    localparam logic [CW-1:0] WR_LAST    = CW'(DIGITS);
    localparam logic [CW-1:0] DIG_LAST   = CW'(DIGITS - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [6:0]    FIELD_ADDR = 7'(LINE_BASE + COL);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_WRITE, S_REPAINT} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [W-1:0]    r_mag;
    logic [BW-1:0]   r_bcd;
    logic            r_neg;
    logic            r_seen;
    logic [7:0]      r_dat;
    logic [6:0]      r_addr;
    logic            r_we;

    logic [W-1:0]    w_mag_in;
    logic [BW-1:0]   w_bcd_adj;
    logic [3:0]      w_digit;
    logic            w_show;

    assign w_mag_in = value[W-1] ? -value : value;
    assign w_digit  = r_bcd[BW-1 -: 4];
    assign w_show   = r_seen || (w_digit != 4'd0) || (r_cnt == DIG_LAST);

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5)
                w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
        end
    end

    always_ff @(posedge CLK12 or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (value_valid)        w_next = S_CONV;
            S_CONV:    if (r_cnt == CONV_LAST) w_next = S_WRITE;
            S_WRITE:   if (r_cnt == WR_LAST)   w_next = S_REPAINT;
            S_REPAINT: if (!lcd_busy)          w_next = S_IDLE;
            default:                           w_next = S_IDLE;
        endcase
    end

    // Ready is masked by reset so every output reads 0 while reset is held.
    always_comb begin
        value_ready = (r_state == S_IDLE) && reset_n;
        lcd_repaint = (r_state == S_REPAINT) && !lcd_busy;
    end

    always_ff @(posedge CLK12 or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_mag  <= '0;
            r_bcd  <= '0;
            r_neg  <= 1'b0;
            r_seen <= 1'b0;
            r_dat  <= 8'h00;
            r_addr <= 7'd0;
            r_we   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (value_valid) begin
                        r_neg  <= value[W-1] && (w_mag_in != '0);
                        r_mag  <= w_mag_in;
                        r_bcd  <= '0;
                        r_cnt  <= '0;
                        r_seen <= 1'b0;
                    end
                end
                S_CONV: begin
                    {r_bcd, r_mag} <= {w_bcd_adj, r_mag} << 1;
                    // The sign character is staged on the final shift so writes start right after conversion.
                    if (r_cnt == CONV_LAST) begin
                        r_cnt  <= '0;
                        r_we   <= 1'b1;
                        r_addr <= FIELD_ADDR;
                        r_dat  <= r_neg ? 8'h2D : 8'h20;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                S_WRITE: begin
                    if (r_cnt != WR_LAST) begin
                        r_addr <= r_addr + 7'd1;
                        r_dat  <= w_show ? {4'h3, w_digit} : 8'h20;
                        r_bcd  <= r_bcd << 4;
                        r_seen <= r_seen || (w_digit != 4'd0);
                        r_cnt  <= r_cnt + CNT_ONE;
                    end else begin
                        r_we <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign lcd_dat  = r_dat;
    assign lcd_addr = r_addr;
    assign lcd_we   = r_we;

endmodule
